// File: rtl/pyc_cdc_sync_filt.sv
// Multi-channel CDC synchroniser with per-channel stability filter and registered edge pulses.
// Optional aborted-change counter enabled by defining PYC_CDC_SYNC_FILT_GLITCH_EN.
module pyc_cdc_sync_filt #(
    parameter int                    CHANNELS = 4,
    parameter int                    STAGES   = 2,
    parameter int                    FILTER   = 0,
    parameter logic [CHANNELS-1:0]   RST_VAL  = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] in,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall
`ifdef PYC_CDC_SYNC_FILT_GLITCH_EN
    ,
    input  logic                glitch_clr,
    output logic [15:0]         glitch_cnt
`endif
);

    localparam int CW = (FILTER == 0) ? 1 : $clog2(FILTER + 1);

    if (STAGES < 1 || CHANNELS < 1) begin : g_param_check
        $fatal(1, "pyc_cdc_sync_filt: STAGES and CHANNELS must both be >= 1");
    end

    logic [STAGES-1:0][CHANNELS-1:0] s_q;
    logic [CHANNELS-1:0]             sl;
    logic [CHANNELS-1:0]             out_q, out_d;
    logic [CHANNELS-1:0]             rise_q, rise_d;
    logic [CHANNELS-1:0]             fall_q, fall_d;
    logic [CHANNELS-1:0][CW-1:0]     cnt_q, cnt_d;

    assign sl = s_q[STAGES-1];

    // NOTE: every signal written here gets its default first, so no path leaves it unassigned (no latch).
    always_comb begin
        out_d = out_q;
        cnt_d = cnt_q;
        for (int c = 0; c < CHANNELS; c++) begin
            if (sl[c] == out_q[c]) begin
                cnt_d[c] = '0;
            end else if (cnt_q[c] == CW'(FILTER)) begin
                out_d[c] = sl[c];
                cnt_d[c] = '0;
            end else begin
                cnt_d[c] = cnt_q[c] + CW'(1);
            end
        end
        rise_d = out_d & ~out_q;
        fall_d = ~out_d & out_q;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q    <= {STAGES{RST_VAL}};
            out_q  <= RST_VAL;
            cnt_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            s_q[0] <= in;
            for (int k = 1; k < STAGES; k++) begin
                s_q[k] <= s_q[k-1];
            end
            out_q  <= out_d;
            cnt_q  <= cnt_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign out  = out_q;
    assign rise = rise_q;
    assign fall = fall_q;

`ifdef PYC_CDC_SYNC_FILT_GLITCH_EN
    logic        abort;
    logic [15:0] glitch_q, glitch_d;

    // A pending change that collapses back to the current output counts as one glitch per cycle.
    always_comb begin
        abort = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (cnt_q[c] != '0 && sl[c] == out_q[c]) begin
                abort = 1'b1;
            end
        end
        glitch_d = glitch_q;
        if (glitch_clr) begin
            glitch_d = '0;
        end else if (abort && glitch_q != 16'hFFFF) begin
            glitch_d = glitch_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            glitch_q <= '0;
        end else begin
            glitch_q <= glitch_d;
        end
    end

    assign glitch_cnt = glitch_q;
`endif

endmodule

// File: tb/tb_pyc_cdc_sync_filt.sv
// Directed bench for pyc_cdc_sync_filt: reset, latency, filtering, edges, mid-filter reset,
// and (with PYC_CDC_SYNC_FILT_GLITCH_EN) the glitch counter.
module tb_pyc_cdc_sync_filt;

    logic       clk = 1'b0;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    // Instance A: STAGES=2, FILTER=0, RST_VAL=0101
    logic       rst_a;
    logic [3:0] in_a, out_a, rise_a, fall_a;
    // Instance B: STAGES=2, FILTER=3, RST_VAL=0
    logic       rst_b;
    logic [3:0] in_b, out_b, rise_b, fall_b;

    pyc_cdc_sync_filt #(.CHANNELS(4), .STAGES(2), .FILTER(0), .RST_VAL(4'b0101)) dut_a (
        .clk(clk), .rst(rst_a), .in(in_a), .out(out_a), .rise(rise_a), .fall(fall_a)
`ifdef PYC_CDC_SYNC_FILT_GLITCH_EN
        , .glitch_clr(1'b0), .glitch_cnt()
`endif
    );

    pyc_cdc_sync_filt #(.CHANNELS(4), .STAGES(2), .FILTER(3), .RST_VAL(4'b0000)) dut_b (
        .clk(clk), .rst(rst_b), .in(in_b), .out(out_b), .rise(rise_b), .fall(fall_b)
`ifdef PYC_CDC_SYNC_FILT_GLITCH_EN
        , .glitch_clr(1'b0), .glitch_cnt()
`endif
    );

`ifdef PYC_CDC_SYNC_FILT_GLITCH_EN
    // Instance C: STAGES=2, FILTER=2, glitch counter exercised
    logic        rst_c, clr_c;
    logic [3:0]  in_c, out_c, rise_c, fall_c;
    logic [15:0] gcnt_c;

    pyc_cdc_sync_filt #(.CHANNELS(4), .STAGES(2), .FILTER(2), .RST_VAL(4'b0000)) dut_c (
        .clk(clk), .rst(rst_c), .in(in_c), .out(out_c), .rise(rise_c), .fall(fall_c),
        .glitch_clr(clr_c), .glitch_cnt(gcnt_c)
    );
`endif

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_a = 1'b0; in_a = 4'b0101;
        rst_b = 1'b0; in_b = 4'b0000;
`ifdef PYC_CDC_SYNC_FILT_GLITCH_EN
        rst_c = 1'b0; in_c = 4'b0000; clr_c = 1'b0;
`endif
        #1;
        rst_a = 1'b1; rst_b = 1'b1;
`ifdef PYC_CDC_SYNC_FILT_GLITCH_EN
        rst_c = 1'b1;
`endif
        #1;
        // Asynchronous reset takes effect before any clock edge
        check("a_async_rst", {20'd0, out_a, rise_a, fall_a}, {20'd0, 4'b0101, 4'b0000, 4'b0000});
        check("b_async_rst", {20'd0, out_b, rise_b, fall_b}, 32'd0);
        tick(2);
        rst_a = 1'b0; rst_b = 1'b0;
`ifdef PYC_CDC_SYNC_FILT_GLITCH_EN
        rst_c = 1'b0;
`endif

        // ---- Instance A: no pulses during the first STAGES+1 cycles after release
        for (int i = 0; i < 3; i++) begin
            tick();
            check("a_post_rst", {20'd0, out_a, rise_a, fall_a}, {20'd0, 4'b0101, 4'b0000, 4'b0000});
        end

        // ch0 1->0: fall exactly 3 edges later
        in_a = 4'b0100;
        tick(2);
        check("a_fall_early", {28'd0, out_a}, 32'h5);
        tick();
        check("a_fall_out", {20'd0, out_a, rise_a, fall_a}, {20'd0, 4'b0100, 4'b0000, 4'b0001});
        tick();
        check("a_fall_clear", {24'd0, rise_a, fall_a}, 32'd0);

        // ch0 0->1: rise exactly 3 edges later, single cycle
        in_a = 4'b0101;
        tick(2);
        check("a_rise_early", {20'd0, out_a, rise_a, fall_a}, {20'd0, 4'b0100, 4'b0000, 4'b0000});
        tick();
        check("a_rise_out", {20'd0, out_a, rise_a, fall_a}, {20'd0, 4'b0101, 4'b0001, 4'b0000});
        tick();
        check("a_rise_clear", {20'd0, out_a, rise_a, fall_a}, {20'd0, 4'b0101, 4'b0000, 4'b0000});

        // Drop all, then all four channels rise together
        in_a = 4'b0000;
        tick(3);
        check("a_drop_all", {20'd0, out_a, rise_a, fall_a}, {20'd0, 4'b0000, 4'b0000, 4'b0101});
        tick();
        in_a = 4'b1111;
        tick(2);
        check("a_all_early", {24'd0, rise_a, fall_a}, 32'd0);
        tick();
        check("a_all_rise", {20'd0, out_a, rise_a, fall_a}, {20'd0, 4'b1111, 4'b1111, 4'b0000});
        tick();
        check("a_all_clear", {20'd0, out_a, rise_a, fall_a}, {20'd0, 4'b1111, 4'b0000, 4'b0000});

        // ---- Instance B (FILTER=3): 3-cycle pulse on ch1 is filtered out
        in_b = 4'b0010;
        tick(3);
        in_b = 4'b0000;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("b_short_pulse", {24'd0, out_b, rise_b}, 32'd0);
        end

        // Held pulse: out follows at edge 6 with one rise
        in_b = 4'b0010;
        for (int n = 1; n <= 8; n++) begin
            tick();
            check("b_long_pulse", {20'd0, out_b, rise_b, fall_b},
                  {20'd0, (n >= 6) ? 4'b0010 : 4'b0000, (n == 6) ? 4'b0010 : 4'b0000, 4'b0000});
        end

        // Mid-filter reset: start 1->0 on ch1, assert rst when cnt has reached 2
        in_b = 4'b0000;
        tick(4);
        check("b_pre_rst", {28'd0, out_b}, 32'h2);
        rst_b = 1'b1;
        #1;
        check("b_mid_rst", {20'd0, out_b, rise_b, fall_b}, 32'd0);
        tick();
        rst_b = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            check("b_after_rst", {20'd0, out_b, rise_b, fall_b}, 32'd0);
        end

`ifdef PYC_CDC_SYNC_FILT_GLITCH_EN
        // ---- Instance C (FILTER=2): five single-cycle glitches on ch2
        check("c_rst_cnt", {16'd0, gcnt_c}, 32'd0);
        for (int g = 0; g < 5; g++) begin
            in_c = 4'b0100;
            tick();
            in_c = 4'b0000;
            tick(4);
        end
        check("c_five", {16'd0, gcnt_c}, 32'd5);
        check("c_out_quiet", {28'd0, out_c}, 32'd0);
        clr_c = 1'b1;
        tick();
        clr_c = 1'b0;
        check("c_clr", {16'd0, gcnt_c}, 32'd0);

        // Alternate ch0/ch1 every cycle: one aborted change per cycle, drives counter to saturation
        for (int i = 0; i < 65600; i++) begin
            in_c = (i % 2 == 0) ? 4'b0001 : 4'b0010;
            tick();
        end
        check("c_sat", {16'd0, gcnt_c}, 32'h0000FFFF);
        for (int i = 0; i < 4; i++) begin
            in_c = (i % 2 == 0) ? 4'b0001 : 4'b0010;
            tick();
        end
        check("c_sat_hold", {16'd0, gcnt_c}, 32'h0000FFFF);
        check("c_sat_out", {28'd0, out_c}, 32'd0);

        // Clear wins over a simultaneous increment
        clr_c = 1'b1;
        in_c  = 4'b0001;
        tick();
        clr_c = 1'b0;
        check("c_clr_prio", {16'd0, gcnt_c}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
